ga_run_controller: RTL and testbench

- Sequences one run of the morphologic GA core. It holds the core in reset, releases it, and counts generations on each `cycle` pulse.
- Stops the run on zero error or on a generation limit.
- Streams report frames (generation, best error, best individual) byte-wise to the serial TX package through a valid/ready handshake.
- Sits between the GA core and the serial TX package in the debug top level; replaces the free-running counter logic there.

---
 rtl/ga_ctrl_pkg.sv | 27 ++
 rtl/ga_report_serializer.sv | 82 ++++++++
 rtl/ga_run_controller.sv | 166 ++++++++++++++++
 tb/tb_ga_run_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_ctrl_pkg.sv
// Shared definitions for the GA run controller: FSM state encoding, frame
// header byte and the report frame length helper.
// Build option: GA_RUN_CTRL_CHECKSUM_EN appends an XOR checksum byte to every frame.
package ga_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

`ifdef GA_RUN_CTRL_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    // Header + generation bytes + error byte + individual bytes (+ checksum).
    function automatic int frame_len(input int gen_w, input int ind_w, input bit cks_en);
        return 2 + gen_w / 8 + ind_w / 8 + (cks_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/ga_report_serializer.sv
// Report frame serializer: loads a {generation, error, individual} snapshot
// and streams it MSB-first behind an 0xA5 header over a valid/ready byte port.
// Build option: GA_RUN_CTRL_CHECKSUM_EN adds a trailing XOR checksum byte.
module ga_report_serializer
    import ga_ctrl_pkg::*;
#(
    parameter int ErrorWidth      = 5,
    parameter int IndividualWidth = 64,
    parameter int GenWidth        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load,
    input  logic [GenWidth-1:0]        i_gen,
    input  logic [ErrorWidth-1:0]      i_err,
    input  logic [IndividualWidth-1:0] i_ind,
    input  logic                       i_tx_ready,
    output logic                       o_tx_valid,
    output logic [7:0]                 o_tx_data,
    output logic                       o_in_flight,
    output logic                       o_last_xfer
);

    localparam int PayloadBytes = frame_len(GenWidth, IndividualWidth, 1'b0);
    localparam int FrameBytes   = frame_len(GenWidth, IndividualWidth, CHECKSUM_EN);
    localparam int PayloadBits  = 8 * PayloadBytes;
    localparam int IdxWidth     = $clog2(FrameBytes);

    logic [PayloadBits-1:0] r_shift;
    logic [IdxWidth-1:0]    r_idx;
    logic                   r_valid;

    logic                   w_xfer;
    logic                   w_last;
    logic [7:0]             w_err_byte;

    assign w_err_byte = 8'(i_err);
    assign w_xfer     = r_valid && i_tx_ready;
    assign w_last     = (r_idx == IdxWidth'(FrameBytes - 1));

    // Byte sequencing: load a snapshot, then shift one byte out per handshake.
    // NOTE: the payload shifter is reset as well, because its top byte is txData and must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= {FRAME_HEADER, i_gen, w_err_byte, i_ind};
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_shift <= r_shift << 8;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef GA_RUN_CTRL_CHECKSUM_EN
    logic [7:0] r_cks;

    // Running XOR of every byte already handed over, header included.
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cks <= '0;
        end else if (w_xfer) begin
            r_cks <= r_cks ^ o_tx_data;
        end
    end

    assign o_tx_data = (r_idx == IdxWidth'(PayloadBytes)) ? r_cks : r_shift[PayloadBits-1 -: 8];
`else
    assign o_tx_data = r_shift[PayloadBits-1 -: 8];
`endif

    assign o_tx_valid  = r_valid;
    assign o_in_flight = r_valid;
    assign o_last_xfer = w_xfer && w_last;

endmodule

// File: rtl/ga_run_controller.sv
// GA run controller: holds the GA core in reset, releases it for one run,
// counts generations, stops on zero error or the generation limit, and
// reports periodic and final snapshots as byte frames to the serial TX.
// Build option: GA_RUN_CTRL_CHECKSUM_EN appends an XOR checksum byte to every frame.
module ga_run_controller
    import ga_ctrl_pkg::*;
#(
    parameter int ErrorWidth      = 5,
    parameter int IndividualWidth = 64,
    parameter int GenWidth        = 32,
    parameter int MaxGenerations  = 100000,
    parameter int ReportPeriod    = 1024,
    parameter int ClearCycles     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cycle,
    input  logic [ErrorWidth-1:0]      bestError,
    input  logic [IndividualWidth-1:0] bestIndividual,
    output logic                       gaRst,
    output logic                       txValid,
    input  logic                       txReady,
    output logic [7:0]                 txData,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [GenWidth-1:0]        generation
);

    // Divisor kept non-zero so the modulo is always well formed; the
    // ReportPeriod==0 case is excluded before it matters.
    localparam int                  ReportDiv   = (ReportPeriod == 0) ? 1 : ReportPeriod;
    localparam int                  ClrWidth    = (ClearCycles > 1) ? $clog2(ClearCycles) : 1;
    localparam logic [GenWidth-1:0] MaxGenValue = GenWidth'(MaxGenerations);

    state_t                     r_state;
    logic [ClrWidth-1:0]        r_clr_cnt;
    logic [GenWidth-1:0]        r_gen;
    logic                       r_done;
    logic                       r_timeout;
    logic                       r_final_loaded;
    logic [GenWidth-1:0]        r_snap_gen;
    logic [ErrorWidth-1:0]      r_snap_err;
    logic [IndividualWidth-1:0] r_snap_ind;

    logic                       w_run_pulse;
    logic [GenWidth-1:0]        w_gen_next;
    logic                       w_hit_done;
    logic                       w_hit_limit;
    logic                       w_terminal;
    logic                       w_periodic;
    logic                       w_load_now;
    logic                       w_load_deferred;
    logic                       w_load;
    logic [GenWidth-1:0]        w_load_gen;
    logic [ErrorWidth-1:0]      w_load_err;
    logic [IndividualWidth-1:0] w_load_ind;
    logic                       w_in_flight;
    logic                       w_last_xfer;

    // Terminal checks use the pre-increment inputs and the post-increment count.
    assign w_run_pulse = (r_state == ST_RUN) && cycle;
    assign w_gen_next  = r_gen + 1'b1;
    assign w_hit_done  = w_run_pulse && (bestError == '0);
    assign w_hit_limit = w_run_pulse && !w_hit_done && (MaxGenerations != 0)
                         && (w_gen_next == MaxGenValue);
    assign w_terminal  = w_hit_done || w_hit_limit;
    assign w_periodic  = w_run_pulse && !w_terminal && (ReportPeriod != 0)
                         && ((w_gen_next % GenWidth'(ReportDiv)) == '0);

    // A frame starts straight from the live inputs when the serializer is free;
    // a final frame that found it busy is sent from the snapshot once it drains.
    // A periodic request that finds it busy is simply dropped.
    assign w_load_now      = (w_terminal || w_periodic) && !w_in_flight;
    assign w_load_deferred = (r_state == ST_FINAL) && !r_final_loaded && !w_in_flight;
    assign w_load          = w_load_now || w_load_deferred;
    assign w_load_gen      = w_load_deferred ? r_snap_gen : w_gen_next;
    assign w_load_err      = w_load_deferred ? r_snap_err : bestError;
    assign w_load_ind      = w_load_deferred ? r_snap_ind : bestIndividual;

    // Run sequencing: IDLE -> CLEAR -> RUN -> FINAL -> DONE, with sync reset.
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_clr_cnt      <= '0;
            r_gen          <= '0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_final_loaded <= 1'b0;
            r_snap_gen     <= '0;
            r_snap_err     <= '0;
            r_snap_ind     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state        <= ST_CLEAR;
                        r_clr_cnt      <= '0;
                        r_gen          <= '0;
                        r_done         <= 1'b0;
                        r_timeout      <= 1'b0;
                        r_final_loaded <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == ClrWidth'(ClearCycles - 1)) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cycle) begin
                        r_gen <= w_gen_next;
                        if (w_terminal) begin
                            r_state        <= ST_FINAL;
                            r_done         <= w_hit_done;
                            r_timeout      <= w_hit_limit;
                            r_snap_gen     <= w_gen_next;
                            r_snap_err     <= bestError;
                            r_snap_ind     <= bestIndividual;
                            r_final_loaded <= !w_in_flight;
                        end
                    end
                end
                ST_FINAL: begin
                    if (w_load_deferred) begin
                        r_final_loaded <= 1'b1;
                    end
                    if (r_final_loaded && w_last_xfer) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ga_report_serializer #(
        .ErrorWidth      (ErrorWidth),
        .IndividualWidth (IndividualWidth),
        .GenWidth        (GenWidth)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_gen       (w_load_gen),
        .i_err       (w_load_err),
        .i_ind       (w_load_ind),
        .i_tx_ready  (txReady),
        .o_tx_valid  (txValid),
        .o_tx_data   (txData),
        .o_in_flight (w_in_flight),
        .o_last_xfer (w_last_xfer)
    );

    assign gaRst      = (r_state != ST_RUN);
    assign busy       = (r_state == ST_CLEAR) || (r_state == ST_RUN)
                        || (r_state == ST_FINAL) || w_in_flight;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign generation = r_gen;

endmodule

// File: tb/tb_ga_run_controller.sv
// Directed self-checking bench for ga_run_controller (MaxGenerations=10,
// ReportPeriod=2). Frames seen on the TX port are compared against frames
// built from the known stimulus; GA_RUN_CTRL_CHECKSUM_EN adds the XOR byte.
module tb_ga_run_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cycle = 1'b0;
    logic [4:0]  bestError = 5'd1;
    logic [63:0] bestIndividual = '0;
    logic        txReady = 1'b0;
    logic        gaRst;
    logic        txValid;
    logic [7:0]  txData;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] generation;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    ga_run_controller #(
        .ErrorWidth      (5),
        .IndividualWidth (64),
        .GenWidth        (32),
        .MaxGenerations  (10),
        .ReportPeriod    (2),
        .ClearCycles     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cycle          (cycle),
        .bestError      (bestError),
        .bestIndividual (bestIndividual),
        .gaRst          (gaRst),
        .txValid        (txValid),
        .txReady        (txReady),
        .txData         (txData),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .generation     (generation)
    );

    // Record each byte that will transfer on the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && txValid && txReady) begin
            rx_q.push_back(txData);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ind_of(input int g);
        return 64'h1122_3344_5566_7700 | 64'(g);
    endfunction

    // Expected frame: A5, generation MSB-first, error byte, individual MSB-first.
    task automatic add_frame(input logic [31:0] g, input logic [4:0] e, input logic [63:0] ind);
        logic [7:0] b[$];
        logic [7:0] x;
        b.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) b.push_back(g[8*i +: 8]);
        b.push_back({3'b000, e});
        for (int i = 7; i >= 0; i--) b.push_back(ind[8*i +: 8]);
`ifdef GA_RUN_CTRL_CHECKSUM_EN
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(x);
`else
        x = 8'h00;
`endif
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic pulse(input logic [4:0] e, input logic [63:0] ind);
        @(negedge clk);
        cycle = 1'b1;
        bestError = e;
        bestIndividual = ind;
        @(negedge clk);
        cycle = 1'b0;
    endtask

    task automatic do_start();
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int n = 0; n < 20 && gaRst; n++) @(negedge clk);
        check({tag, "_run_entry"}, 64'(gaRst), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 300 && busy; n++) @(negedge clk);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int clr_n;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_gaRst", 64'(gaRst), 64'd1);
        check("rst_txValid", 64'(txValid), 64'd0);
        check("rst_txData", 64'(txData), 64'h0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_generation", 64'(generation), 64'd0);

        // Reset during CLEAR returns to IDLE and stays there.
        do_start();
        @(negedge clk);
        check("clr_busy", 64'(busy), 64'd1);
        check("clr_gaRst", 64'(gaRst), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("clr_rst_busy", 64'(busy), 64'd0);
        check("clr_rst_gaRst", 64'(gaRst), 64'd1);
        check("clr_rst_txValid", 64'(txValid), 64'd0);
        check("clr_rst_generation", 64'(generation), 64'd0);
        repeat (6) @(negedge clk);
        check("clr_rst_stay_gaRst", 64'(gaRst), 64'd1);
        check("clr_rst_stay_busy", 64'(busy), 64'd0);

        // Run ending on zero error at generation 4; the gen-2 report is still
        // on the wire when the final pulse arrives, so the final frame follows it.
        txReady = 1'b1;
        do_start();
        clr_n = 0;
        while (gaRst && clr_n < 20) begin
            clr_n++;
            @(negedge clk);
        end
        check("clear_cycles", 64'(clr_n), 64'd4);
        pulse(5'd7, 64'hDEAD_BEEF_0000_0001);
        pulse(5'd7, 64'h0102_0304_0506_0708);
        check("lat_txValid", 64'(txValid), 64'd1);
        check("lat_txData", 64'(txData), 64'hA5);
        pulse(5'd7, 64'hCAFE_0000_0000_0003);
        pulse(5'd0, 64'h0);
        check("fin_done", 64'(done), 64'd1);
        check("fin_timeout", 64'(timeout), 64'd0);
        check("fin_gaRst", 64'(gaRst), 64'd1);
        check("fin_busy", 64'(busy), 64'd1);
        add_frame(32'd2, 5'd7, 64'h0102_0304_0506_0708);
        add_frame(32'd4, 5'd0, 64'h0);
        wait_idle("t2");
        check("t2_generation", 64'(generation), 64'd4);
        check("t2_done", 64'(done), 64'd1);
        check("t2_gaRst", 64'(gaRst), 64'd1);
        compare_frames("t2");
`ifdef GA_RUN_CTRL_CHECKSUM_EN
        // A5 ^ 04 with every other byte zero.
        check("t2_checksum", (rx_q.size() > 0) ? 64'(rx_q[$]) : 64'hFFFF, 64'hA1);
`endif

        // Generation limit: periodic frames at 2,4,6,8, timeout frame at 10.
        do_start();
        wait_run("t3");
        for (int g = 1; g <= 10; g++) begin
            pulse(5'd3, ind_of(g));
            if (g % 2 == 0 && g < 10) add_frame(32'(g), 5'd3, ind_of(g));
            if (g == 10) begin
                check("t3_timeout_now", 64'(timeout), 64'd1);
                check("t3_done_now", 64'(done), 64'd0);
            end
            repeat (18) @(negedge clk);
        end
        add_frame(32'd10, 5'd3, ind_of(10));
        wait_idle("t3");
        check("t3_timeout", 64'(timeout), 64'd1);
        check("t3_generation", 64'(generation), 64'd10);
        compare_frames("t3");
        pulse(5'd3, ind_of(11));
        repeat (3) @(negedge clk);
        check("t3_done_ignores_cycle", 64'(generation), 64'd10);
        check("t3_done_txValid", 64'(txValid), 64'd0);

        // Stalled TX: gen-2 frame holds on the header, gen-4 report is dropped.
        txReady = 1'b0;
        do_start();
        wait_run("t4");
        pulse(5'd5, ind_of(1));
        pulse(5'd5, ind_of(2));
        check("t4_stall_valid0", 64'(txValid), 64'd1);
        check("t4_stall_data0", 64'(txData), 64'hA5);
        pulse(5'd5, ind_of(3));
        pulse(5'd5, ind_of(4));
        repeat (3) @(negedge clk);
        check("t4_stall_valid1", 64'(txValid), 64'd1);
        check("t4_stall_data1", 64'(txData), 64'hA5);
        check("t4_stall_busy", 64'(busy), 64'd1);
        check("t4_generation", 64'(generation), 64'd4);
        add_frame(32'd2, 5'd5, ind_of(2));
        txReady = 1'b1;
        for (int n = 0; n < 100 && txValid; n++) @(negedge clk);
        check("t4_drain", 64'(txValid), 64'd0);
        repeat (5) @(negedge clk);
        compare_frames("t4_periodic");
        pulse(5'd0, ind_of(5));
        add_frame(32'd5, 5'd0, ind_of(5));
        wait_idle("t4");
        check("t4_done", 64'(done), 64'd1);
        compare_frames("t4_all");

        // Zero error on the pulse that reaches the limit: done wins.
        do_start();
        wait_run("t5");
        for (int g = 1; g <= 9; g++) begin
            pulse(5'd1, ind_of(g));
            if (g % 2 == 0) add_frame(32'(g), 5'd1, ind_of(g));
            repeat (18) @(negedge clk);
        end
        pulse(5'd0, ind_of(10));
        check("t5_done_now", 64'(done), 64'd1);
        check("t5_timeout_now", 64'(timeout), 64'd0);
        add_frame(32'd10, 5'd0, ind_of(10));
        wait_idle("t5");
        check("t5_generation", 64'(generation), 64'd10);
        check("t5_timeout", 64'(timeout), 64'd0);
        compare_frames("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
